reset_sequencer: RTL and testbench



---
 rtl/reset_sequencer.sv | 168 ++++++++++++++++
 tb/tb_reset_sequencer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// reset_sequencer: holds the core in reset, waits for a qualified hold period,
//   then releases NUM_STAGES reset domains in order, STAGE_GAP cycles apart.
// Latency: last stage, clr_pc and enable_pd change HOLD_CYCLES-1+NUM_STAGES*STAGE_GAP
//   edges after the first edge with reset low and ext_ready high.
// Backpressure: none; ext_ready stalls the hold count, soft_rst_req is only honoured in RUN.
//
// Ports:
//   clk, reset        system clock, synchronous active-high hard reset
//   ext_ready         external qualifier; the hold period counts only while high
//   soft_rst_req      warm-reset request, acted on only while in RUN
//   stage_rst         per-domain active-high resets, bit 0 released first
//   clr_pc            clears the program counter until the last stage releases
//   enable_pd         enables program/data execution once the sequence is done
//   busy              sequence in progress (HOLD or RELEASE)
//   seq_done          one-cycle pulse on entry to RUN
//   rst_cause         last reset source: 01 hard, 10 soft

module reset_sequencer #(
  parameter int NUM_STAGES  = 3,
  parameter int HOLD_CYCLES = 4,
  parameter int STAGE_GAP   = 1,
  parameter int CNT_W       = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ext_ready,
  input  logic                  soft_rst_req,
  output logic [NUM_STAGES-1:0] stage_rst,
  output logic                  clr_pc,
  output logic                  enable_pd,
  output logic                  busy,
  output logic                  seq_done,
  output logic [1:0]            rst_cause
);

  localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_STAGES - 1);

  localparam logic [1:0] CAUSE_HARD = 2'b01;
  localparam logic [1:0] CAUSE_SOFT = 2'b10;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [NUM_STAGES-1:0]   stage_rst_q, stage_rst_d;
  logic                    clr_pc_q, clr_pc_d;
  logic                    enable_pd_q, enable_pd_d;
  logic                    busy_q, busy_d;
  logic                    seq_done_q, seq_done_d;
  logic [1:0]              rst_cause_q, rst_cause_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    stage_rst_d = stage_rst_q;
    clr_pc_d    = clr_pc_q;
    enable_pd_d = enable_pd_q;
    busy_d      = busy_q;
    seq_done_d  = 1'b0;
    rst_cause_d = rst_cause_q;

    case (state_q)
      ST_HOLD: begin
        // Any dropout of the qualifier restarts the hold from zero.
        if (ext_ready) begin
          if (cnt_q == HOLD_LAST) begin
            cnt_d   = '0;
            idx_d   = '0;
            state_d = ST_RELEASE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          cnt_d = '0;
        end
      end

      ST_RELEASE: begin
        if (cnt_q == GAP_LAST) begin
          // Clear only the bit selected by idx; loop avoids an
          // out-of-range select when NUM_STAGES is not a power of two.
          for (int i = 0; i < NUM_STAGES; i++) begin
            if (idx_q == IDX_W'(i)) begin
              stage_rst_d[i] = 1'b0;
            end
          end
          cnt_d = '0;
          idx_d = idx_q + 1'b1;
          if (idx_q == IDX_LAST) begin
            clr_pc_d    = 1'b0;
            enable_pd_d = 1'b1;
            busy_d      = 1'b0;
            seq_done_d  = 1'b1;
            state_d     = ST_RUN;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_RUN: begin
        if (soft_rst_req) begin
          state_d     = ST_HOLD;
          cnt_d       = '0;
          idx_d       = '0;
          stage_rst_d = '1;
          clr_pc_d    = 1'b1;
          enable_pd_d = 1'b0;
          busy_d      = 1'b1;
          rst_cause_d = CAUSE_SOFT;
        end
      end

      default: begin
        state_d     = ST_HOLD;
        cnt_d       = '0;
        idx_d       = '0;
        stage_rst_d = '1;
        clr_pc_d    = 1'b1;
        enable_pd_d = 1'b0;
        busy_d      = 1'b1;
      end
    endcase
  end

  // Hard reset overrides everything, including a simultaneous soft request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_HOLD;
      cnt_q       <= '0;
      idx_q       <= '0;
      stage_rst_q <= '1;
      clr_pc_q    <= 1'b1;
      enable_pd_q <= 1'b0;
      busy_q      <= 1'b1;
      seq_done_q  <= 1'b0;
      rst_cause_q <= CAUSE_HARD;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      stage_rst_q <= stage_rst_d;
      clr_pc_q    <= clr_pc_d;
      enable_pd_q <= enable_pd_d;
      busy_q      <= busy_d;
      seq_done_q  <= seq_done_d;
      rst_cause_q <= rst_cause_d;
    end
  end

  assign stage_rst = stage_rst_q;
  assign clr_pc    = clr_pc_q;
  assign enable_pd = enable_pd_q;
  assign busy      = busy_q;
  assign seq_done  = seq_done_q;
  assign rst_cause = rst_cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed bench for reset_sequencer, default instance plus
//   a NUM_STAGES=1 / HOLD_CYCLES=1 / STAGE_GAP=3 instance.
// Outputs are sampled 1 time unit after each rising edge.

module tb_reset_sequencer;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic       reset = 1'b1;
  logic       ext_ready = 1'b0;
  logic       soft_rst_req = 1'b0;
  logic [2:0] stage_rst;
  logic       clr_pc, enable_pd, busy, seq_done;
  logic [1:0] rst_cause;

  // Single-stage instance
  logic       reset_b = 1'b1;
  logic       ext_ready_b = 1'b0;
  logic       soft_rst_req_b = 1'b0;
  logic [0:0] stage_rst_b;
  logic       clr_pc_b, enable_pd_b, busy_b, seq_done_b;
  logic [1:0] rst_cause_b;

  reset_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .ext_ready    (ext_ready),
    .soft_rst_req (soft_rst_req),
    .stage_rst    (stage_rst),
    .clr_pc       (clr_pc),
    .enable_pd    (enable_pd),
    .busy         (busy),
    .seq_done     (seq_done),
    .rst_cause    (rst_cause)
  );

  reset_sequencer #(
    .NUM_STAGES  (1),
    .HOLD_CYCLES (1),
    .STAGE_GAP   (3),
    .CNT_W       (8)
  ) dut_b (
    .clk          (clk),
    .reset        (reset_b),
    .ext_ready    (ext_ready_b),
    .soft_rst_req (soft_rst_req_b),
    .stage_rst    (stage_rst_b),
    .clr_pc       (clr_pc_b),
    .enable_pd    (enable_pd_b),
    .busy         (busy_b),
    .seq_done     (seq_done_b),
    .rst_cause    (rst_cause_b)
  );

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected default-instance outputs r edges after E0 (first qualified edge),
  // from the release formula: stage k drops at E0 + 3 + (k+1).
  task automatic expect_seq(input string tag, input int r, input logic [1:0] cause);
    logic [2:0] exp_st;
    for (int k = 0; k < 3; k++) exp_st[k] = (r >= 3 + (k + 1)) ? 1'b0 : 1'b1;
    check({tag, ".stage_rst"}, 32'(stage_rst), 32'(exp_st));
    check({tag, ".clr_pc"},    32'(clr_pc),    (r >= 6) ? 32'd0 : 32'd1);
    check({tag, ".enable_pd"}, 32'(enable_pd), (r >= 6) ? 32'd1 : 32'd0);
    check({tag, ".busy"},      32'(busy),      (r >= 6) ? 32'd0 : 32'd1);
    check({tag, ".seq_done"},  32'(seq_done),  (r == 6) ? 32'd1 : 32'd0);
    check({tag, ".rst_cause"}, 32'(rst_cause), 32'(cause));
  endtask

  task automatic expect_run(input string tag, input logic [1:0] cause);
    check({tag, ".stage_rst"}, 32'(stage_rst), 32'd0);
    check({tag, ".clr_pc"},    32'(clr_pc),    32'd0);
    check({tag, ".enable_pd"}, 32'(enable_pd), 32'd1);
    check({tag, ".busy"},      32'(busy),      32'd0);
    check({tag, ".seq_done"},  32'(seq_done),  32'd0);
    check({tag, ".rst_cause"}, 32'(rst_cause), 32'(cause));
  endtask

  task automatic expect_held(input string tag, input logic [1:0] cause);
    check({tag, ".stage_rst"}, 32'(stage_rst), 32'd7);
    check({tag, ".clr_pc"},    32'(clr_pc),    32'd1);
    check({tag, ".enable_pd"}, 32'(enable_pd), 32'd0);
    check({tag, ".busy"},      32'(busy),      32'd1);
    check({tag, ".seq_done"},  32'(seq_done),  32'd0);
    check({tag, ".rst_cause"}, 32'(rst_cause), 32'(cause));
  endtask

  int pulses;

  initial begin
    // ---- 1: hard reset, then straight release with ext_ready high
    reset = 1'b1; ext_ready = 1'b1; soft_rst_req = 1'b0;
    repeat (3) tick();
    expect_held("t1_reset", 2'b01);
    reset = 1'b0;
    for (int r = 0; r < 9; r++) begin
      tick();
      expect_seq($sformatf("t1_e%0d", r), r, 2'b01);
    end
    // ext_ready dropping in RUN has no effect
    ext_ready = 1'b0;
    repeat (3) tick();
    expect_run("t1_run_noready", 2'b01);

    // ---- 2: qualifier dropout during HOLD restarts the count
    reset = 1'b1; ext_ready = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();                           // E0 counts once
    ext_ready = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      tick();
      expect_held($sformatf("t2_low_e%0d", e), 2'b01);
    end
    ext_ready = 1'b1;                 // E6 becomes the new E0
    for (int r = 0; r < 8; r++) begin
      tick();
      expect_seq($sformatf("t2_e%0d", r), r, 2'b01);
    end

    // ---- 3: one-cycle soft request from RUN
    soft_rst_req = 1'b1;
    tick();
    soft_rst_req = 1'b0;
    expect_held("t3_soft", 2'b10);
    pulses = 0;
    for (int r = 0; r < 8; r++) begin
      tick();
      if (seq_done) pulses++;
      expect_seq($sformatf("t3_e%0d", r), r, 2'b10);
    end
    check("t3_pulse_count", 32'(pulses), 32'd1);

    // ---- 4: soft request held high through a whole sequence
    soft_rst_req = 1'b1;
    tick();
    expect_held("t4_soft", 2'b10);
    for (int r = 0; r <= 6; r++) begin
      tick();
      expect_seq($sformatf("t4_e%0d", r), r, 2'b10);
    end
    tick();                           // first edge sampled in RUN re-triggers
    soft_rst_req = 1'b0;
    expect_held("t4_retrigger", 2'b10);

    // ---- 5: hard reset (with soft) mid-release
    for (int r = 0; r <= 4; r++) begin
      tick();
      expect_seq($sformatf("t5_pre_e%0d", r), r, 2'b10);
    end
    reset = 1'b1; soft_rst_req = 1'b1;
    tick();
    expect_held("t5_hard", 2'b01);
    reset = 1'b0; soft_rst_req = 1'b0;
    for (int r = 0; r < 8; r++) begin
      tick();
      expect_seq($sformatf("t5_e%0d", r), r, 2'b01);
    end

    // ---- 6: single stage, HOLD_CYCLES=1, STAGE_GAP=3
    reset_b = 1'b1; ext_ready_b = 1'b1; soft_rst_req_b = 1'b0;
    repeat (2) tick();
    check("t6_reset.stage_rst", 32'(stage_rst_b), 32'd1);
    check("t6_reset.rst_cause", 32'(rst_cause_b), 32'd1);
    reset_b = 1'b0;
    for (int r = 0; r <= 4; r++) begin
      tick();
      check($sformatf("t6_e%0d.stage_rst", r), 32'(stage_rst_b), (r >= 3) ? 32'd0 : 32'd1);
      check($sformatf("t6_e%0d.clr_pc", r),    32'(clr_pc_b),    (r >= 3) ? 32'd0 : 32'd1);
      check($sformatf("t6_e%0d.enable_pd", r), 32'(enable_pd_b), (r >= 3) ? 32'd1 : 32'd0);
      check($sformatf("t6_e%0d.busy", r),      32'(busy_b),      (r >= 3) ? 32'd0 : 32'd1);
      check($sformatf("t6_e%0d.seq_done", r),  32'(seq_done_b),  (r == 3) ? 32'd1 : 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
